bpm_monitor_mc: RTL and testbench
=================================

# bpm_monitor_mc

Multi-channel, parametrised heart-rate monitor. It counts beat pulses per channel over a fixed measurement window and converts each count to BPM with saturation. It flags abnormal windows against configurable thresholds and raises a sticky per-channel alarm after a configurable run of consecutive abnormal windows. It sits between the per-lead beat detectors and the display/alarm logic, and is the multi-channel successor to the single-channel pulse-count-to-BPM monitor.

## Interface
Parameters:
- CHANNELS, 4, number of independent monitored channels
- CNT_W, 8, pulse counter width per channel (saturating)
- BPM_W, 10, BPM output width per channel (saturating)
- WINDOW_CYCLES, 1000, clocks per measurement window (≥2)
- MULT, 6, count-to-BPM multiplier (60 s / window length in s)
- LOW_TH, 10, count below this is abnormal
- HIGH_TH, 17, count above this is abnormal
- ALARM_WINDOWS, 3, consecutive abnormal windows to raise alarm (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- en  in  1  monitoring enable
- pulse_in  in  CHANNELS  beat level per channel, synchronous to clk
- alarm_clr  in  CHANNELS  per-channel alarm clear, one-cycle strobe
- bpm  out  CHANNELS*BPM_W  channel c at bits [c*BPM_W +: BPM_W]
- bpm_valid  out  1  one-cycle strobe: bpm/bpm_state updated
- bpm_state  out  CHANNELS  1 = last window abnormal
- alarm  out  CHANNELS  sticky abnormal-run alarm

## Operation
- Edge detect per channel: pulse_d registers pulse_in. Beat = pulse_in & ~pulse_d. A level held high counts once.
- Pulse counter: increments on beat and saturates at 2^CNT_W−1.
- Window counter: runs 0..WINDOW_CYCLES−1 while en=1. Terminal cycle (TC) = count WINDOW_CYCLES−1.
- At TC, per channel:
  - bpm ← min(cnt*MULT, 2^BPM_W−1). Product computed at CNT_W+ceil(log2(MULT+1)) bits before clamping.
  - bpm_state ← (cnt < LOW_TH) || (cnt > HIGH_TH).
  - Pulse counter ← 1 if a beat occurs in the TC cycle, else 0. The TC beat belongs to the next window.
  - Window counter wraps to 0.
- Run counter per channel:
  - Abnormal window: increments, saturating at ALARM_WINDOWS.
  - Normal window: clears to 0.
- alarm set: at the TC where the run counter reaches ALARM_WINDOWS. It then stays set through later windows, whether abnormal or normal.
- alarm clear: alarm_clr[c] clears alarm[c] and the run counter. If clear and set coincide, set wins.
- en=0:
  - Window and pulse counters are held at 0; no bpm_valid is produced.
  - bpm, bpm_state, alarm and run counters keep their values. Edge detector keeps tracking.
  - en rising starts a fresh window at count 0.
- Channels are fully independent except for the shared window counter.

## Timing
- Reset values: bpm=0, bpm_valid=0, bpm_state=0, alarm=0. All counters and pulse_d = 0.
- A beat is visible in the counter one clock after the edge.
- bpm, bpm_state, alarm and bpm_valid all update on the clock edge that ends the TC cycle, and are coherent in the same cycle.
- bpm_valid is high for exactly one cycle per window. First strobe comes WINDOW_CYCLES clocks after en rises.
- Reset asserted mid-window: immediate clear. The window restarts at 0 on the first clock with reset low and en=1.

## Configuration
- BPM_MON_AVG_EN defined:
  - Per-channel prev_cnt register, holding the last window's count (reset 0, held while en=0).
  - bpm ← min(((cnt+prev_cnt)>>1)*MULT, 2^BPM_W−1), using a floor average.
  - bpm_state and alarm still use the raw current count.
- BPM_MON_AVG_EN undefined: no prev_cnt storage; bpm is from the raw count only.

## Test plan
Bench parameters: WINDOW_CYCLES=100, defaults otherwise.
- Reset then idle, en=0 for 300 cycles → all outputs 0, no bpm_valid.
- en=1, ch0 12 beats in window, ch1 14 beats → bpm_valid at cycle 100 with bpm0=72, bpm1=84, bpm_state=0000.
- ch2 5 beats per window for 3 windows → bpm2=30, bpm_state[2]=1 each window; alarm[2] rises with the 3rd strobe. It stays set after a 12-beat window. alarm_clr[2] drops it. Clear asserted at a set TC → alarm stays 1.
- Beat on TC cycle only (cycle 99) → current bpm0=0; next window reports 1 beat (bpm0=6).
- WINDOW_CYCLES=600, ch3 toggles every 2 cycles (300 beats, count saturates at 255) → bpm3=1023 (clamped), bpm_state[3]=1.
- Reset pulse at cycle 50 of a window after 8 beats → outputs 0 immediately; next strobe is 100 cycles after reset release and reflects only post-reset beats. With BPM_MON_AVG_EN: windows of 12 then 16 beats → bpm0=36 then 84.

Source files
------------

// File: rtl/bpm_monitor_mc.sv
// Multi-channel beat counter with windowed BPM conversion, abnormal-window flag and sticky alarm.
// Optional BPM_MON_AVG_EN: BPM from the floor average of the current and previous window counts.
module bpm_monitor_mc #(
   parameter int CHANNELS      = 4,
   parameter int CNT_W         = 8,
   parameter int BPM_W         = 10,
   parameter int WINDOW_CYCLES = 1000,
   parameter int MULT          = 6,
   parameter int LOW_TH        = 10,
   parameter int HIGH_TH       = 17,
   parameter int ALARM_WINDOWS = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic [CHANNELS-1:0]       pulse_in,
   input  logic [CHANNELS-1:0]       alarm_clr,
   output logic [CHANNELS*BPM_W-1:0] bpm,
   output logic                      bpm_valid,
   output logic [CHANNELS-1:0]       bpm_state,
   output logic [CHANNELS-1:0]       alarm
);

   localparam int WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam int PROD_W = CNT_W + $clog2(MULT + 1);
   localparam int RUN_W  = (ALARM_WINDOWS > 1) ? $clog2(ALARM_WINDOWS + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [BPM_W-1:0] BPM_MAX = '1;

   logic [WIN_W-1:0] win_q, win_d;
   logic             tc;
   logic             valid_q;

   assign tc        = en && (win_q == WIN_W'(WINDOW_CYCLES - 1));
   assign bpm_valid = valid_q;

   always_comb begin
      win_d = '0;
      if (en && !tc)
         win_d = win_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         win_q   <= win_d;
         valid_q <= tc;
      end
   end

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic              pulse_q;
      logic              beat;
      logic [CNT_W-1:0]  cnt_q, cnt_d;
      logic [RUN_W-1:0]  run_q, run_d, run_inc;
      logic              alarm_q, alarm_d;
      logic              state_q, state_d;
      logic [BPM_W-1:0]  bpm_q, bpm_d;
      logic [CNT_W-1:0]  src;
      logic [PROD_W-1:0] prod;
      logic              abnormal;
      logic              set;

      assign beat     = pulse_in[gi] & ~pulse_q;
      assign abnormal = (int'(cnt_q) < LOW_TH) || (int'(cnt_q) > HIGH_TH);
      assign run_inc  = (run_q == RUN_W'(ALARM_WINDOWS)) ? run_q : run_q + 1'b1;
      assign set      = tc && abnormal && (run_inc == RUN_W'(ALARM_WINDOWS));

`ifdef BPM_MON_AVG_EN
      logic [CNT_W-1:0] prev_q;
      logic [CNT_W:0]   sum;
      assign sum = {1'b0, cnt_q} + {1'b0, prev_q};
      assign src = sum[CNT_W:1];

      always_ff @(posedge clk or posedge reset) begin
         if (reset)
            prev_q <= '0;
         else if (tc)
            prev_q <= cnt_q;
      end
`else
      assign src = cnt_q;
`endif

      assign prod = PROD_W'(src) * PROD_W'(MULT);

      always_comb begin
         cnt_d = cnt_q;
         if (!en)
            cnt_d = '0;
         else if (tc)
            cnt_d = CNT_W'(beat);   // a beat on the terminal cycle opens the next window
         else if (beat && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + 1'b1;
      end

      always_comb begin
         run_d = run_q;
         if (set)
            run_d = RUN_W'(ALARM_WINDOWS);
         else if (alarm_clr[gi])
            run_d = '0;
         else if (tc)
            run_d = abnormal ? run_inc : '0;
      end

      always_comb begin
         alarm_d = set | (alarm_q & ~alarm_clr[gi]);
         state_d = tc ? abnormal : state_q;
         bpm_d   = bpm_q;
         if (tc)
            bpm_d = ((prod >> BPM_W) != '0) ? BPM_MAX : BPM_W'(prod);
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            pulse_q <= 1'b0;
            cnt_q   <= '0;
            run_q   <= '0;
            alarm_q <= 1'b0;
            state_q <= 1'b0;
            bpm_q   <= '0;
         end else begin
            pulse_q <= pulse_in[gi];
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            alarm_q <= alarm_d;
            state_q <= state_d;
            bpm_q   <= bpm_d;
         end
      end

      assign bpm[gi*BPM_W +: BPM_W] = bpm_q;
      assign bpm_state[gi]          = state_q;
      assign alarm[gi]              = alarm_q;
   end

endmodule

// File: tb/tb_bpm_monitor_mc.sv
// Scoreboard bench for bpm_monitor_mc: 100-cycle-window instance for the main scenarios,
// a 600-cycle-window instance for count and BPM saturation.
module tb_bpm_monitor_mc;

   logic        clk = 1'b0;
   logic        reset, en, rst2, en2;
   logic [3:0]  pulse_in, alarm_clr, pulse2, clr2;
   logic [39:0] bpm, bpm2;
   logic        bpm_valid, bpm_valid2;
   logic [3:0]  bpm_state, alarm, bpm_state2, alarm2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [39:0] bpm;
      logic [3:0]  st;
      logic [3:0]  al;
      int          due;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   exp_t last1;

   int         m_carry[4];
   int         m_prev[4];
   int         m_run[4];
   logic [3:0] m_alarm;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bpm_monitor_mc #(.WINDOW_CYCLES(100)) u_dut (
      .clk(clk), .reset(reset), .en(en), .pulse_in(pulse_in), .alarm_clr(alarm_clr),
      .bpm(bpm), .bpm_valid(bpm_valid), .bpm_state(bpm_state), .alarm(alarm)
   );

   bpm_monitor_mc #(.WINDOW_CYCLES(600)) u_dut600 (
      .clk(clk), .reset(rst2), .en(en2), .pulse_in(pulse2), .alarm_clr(clr2),
      .bpm(bpm2), .bpm_valid(bpm_valid2), .bpm_state(bpm_state2), .alarm(alarm2)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, want, want);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_bpm"},   64'(bpm),       64'd0);
      chk({tag, "_valid"}, 64'(bpm_valid), 64'd0);
      chk({tag, "_state"}, 64'(bpm_state), 64'd0);
      chk({tag, "_alarm"}, 64'(alarm),     64'd0);
   endtask

   task automatic model_reset();
      for (int c = 0; c < 4; c++) begin
         m_carry[c] = 0;
         m_prev[c]  = 0;
         m_run[c]   = 0;
      end
      m_alarm = '0;
   endtask

   // Reference behaviour for one terminal cycle; pushes the expected strobe.
   task automatic model_tc(input int n[4], input logic [3:0] tcb, input logic [3:0] clr_tc);
      exp_t e;
      e.bpm = '0;
      e.st  = '0;
      for (int c = 0; c < 4; c++) begin
         int cnt, src, b, inc;
         logic abn, set;
         cnt = m_carry[c] + n[c];
         if (cnt > 255) cnt = 255;
         m_carry[c] = tcb[c] ? 1 : 0;
         abn = (cnt < 10) || (cnt > 17);
`ifdef BPM_MON_AVG_EN
         src = (cnt + m_prev[c]) / 2;
`else
         src = cnt;
`endif
         m_prev[c] = cnt;
         b = src * 6;
         if (b > 1023) b = 1023;
         e.bpm[c*10 +: 10] = 10'(b);
         e.st[c] = abn;
         inc = (m_run[c] + 1 > 3) ? 3 : m_run[c] + 1;
         set = abn && (inc == 3);
         if (set) begin
            m_run[c] = 3;
            m_alarm[c] = 1'b1;
         end else if (clr_tc[c]) begin
            m_run[c] = 0;
            m_alarm[c] = 1'b0;
         end else begin
            m_run[c] = abn ? inc : 0;
         end
      end
      e.al  = m_alarm;
      e.due = cyc + 1;
      q1.push_back(e);
      last1 = e;
   endtask

   // One full 100-cycle window; channel c beats at odd cycles 1..2n-1.
   task automatic window(input int n0, input int n1, input int n2, input int n3,
                         input logic [3:0] tcb, input logic [3:0] clr_mid,
                         input logic [3:0] clr_tc);
      int n[4];
      n[0] = n0; n[1] = n1; n[2] = n2; n[3] = n3;
      for (int i = 0; i < 100; i++) begin
         logic [3:0] p;
         p = '0;
         for (int c = 0; c < 4; c++) begin
            if ((i % 2 == 1) && (i / 2 < n[c])) p[c] = 1'b1;
            if ((i == 99) && tcb[c]) p[c] = 1'b1;
         end
         pulse_in  = p;
         alarm_clr = (i == 50) ? clr_mid : (i == 99) ? clr_tc : 4'b0000;
         if (i == 50) begin
            for (int c = 0; c < 4; c++)
               if (clr_mid[c]) begin
                  m_alarm[c] = 1'b0;
                  m_run[c]   = 0;
               end
         end
         if (i == 99) model_tc(n, tcb, clr_tc);
         @(posedge clk); #1;
      end
      pulse_in  = '0;
      alarm_clr = '0;
   endtask

   always @(negedge clk) begin
      if (bpm_valid === 1'b1) begin
         if (q1.size() == 0) begin
            chk("unexpected_strobe", 64'(bpm_valid), 64'd0);
         end else begin
            exp_t e;
            e = q1.pop_front();
            $display("strobe @%0d bpm=%h state=%b alarm=%b", cyc, bpm, bpm_state, alarm);
            chk("strobe_time", 64'(cyc), 64'(e.due));
            chk("bpm",         64'(bpm), 64'(e.bpm));
            chk("bpm_state",   64'(bpm_state), 64'(e.st));
            chk("alarm",       64'(alarm), 64'(e.al));
         end
      end
   end

   always @(negedge clk) begin
      if (bpm_valid2 === 1'b1) begin
         if (q2.size() == 0) begin
            chk("unexpected_strobe600", 64'(bpm_valid2), 64'd0);
         end else begin
            exp_t e;
            e = q2.pop_front();
            $display("strobe600 @%0d bpm=%h state=%b alarm=%b", cyc, bpm2, bpm_state2, alarm2);
            chk("strobe_time600", 64'(cyc), 64'(e.due));
            chk("bpm600",         64'(bpm2), 64'(e.bpm));
            chk("bpm_state600",   64'(bpm_state2), 64'(e.st));
            chk("alarm600",       64'(alarm2), 64'(e.al));
         end
      end
   end

   initial begin
      reset = 1'b1; en = 1'b0; pulse_in = '0; alarm_clr = '0;
      rst2  = 1'b1; en2 = 1'b0; pulse2 = '0; clr2 = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_idle("reset");
      reset = 1'b0;
      rst2  = 1'b0;
      repeat (300) @(posedge clk);
      #1;
      chk_idle("idle");

      en = 1'b1;
      window(12, 14, 12, 12, 4'b0000, 4'b0000, 4'b0000);
      window(12, 14,  5, 12, 4'b0000, 4'b0000, 4'b0000);
      window(12, 14,  5, 12, 4'b0000, 4'b0000, 4'b0000);
      window(12, 14,  5, 12, 4'b0000, 4'b0000, 4'b0000);
      window(12, 14, 12, 12, 4'b0000, 4'b0000, 4'b0000);
      window(12, 14, 12, 12, 4'b0000, 4'b0100, 4'b0000);
      window(12, 14,  5, 12, 4'b0000, 4'b0000, 4'b0000);
      window(12, 14,  5, 12, 4'b0000, 4'b0000, 4'b0000);
      window(12, 14,  5, 12, 4'b0000, 4'b0000, 4'b0100);
      window( 0, 14, 12, 12, 4'b0001, 4'b0000, 4'b0000);
      window( 0, 14, 12, 12, 4'b0000, 4'b0000, 4'b0000);

      // Partial window with 8 beats on ch0, then reset at cycle 50.
      for (int i = 0; i < 50; i++) begin
         pulse_in = ((i % 2 == 1) && (i / 2 < 8)) ? 4'b0001 : 4'b0000;
         @(posedge clk); #1;
      end
      reset = 1'b1;
      #1;
      chk_idle("midreset");
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      window(12, 12, 12, 12, 4'b0000, 4'b0000, 4'b0000);
      window(16, 12, 12, 12, 4'b0000, 4'b0000, 4'b0000);

      en = 1'b0;
      repeat (150) @(posedge clk);
      #1;
      chk("hold_bpm",   64'(bpm),       64'(last1.bpm));
      chk("hold_alarm", 64'(alarm),     64'(last1.al));

      // Saturation: ch3 toggles every cycle pair for a 600-cycle window.
      en2 = 1'b1;
      for (int i = 0; i < 600; i++) begin
         pulse2 = (i % 2 == 0) ? 4'b1000 : 4'b0000;
         if (i == 599) begin
            exp_t e;
            e.bpm = '0;
`ifdef BPM_MON_AVG_EN
            e.bpm[39:30] = 10'd762;
`else
            e.bpm[39:30] = 10'd1023;
`endif
            e.st  = 4'b1111;
            e.al  = 4'b0000;
            e.due = cyc + 1;
            q2.push_back(e);
         end
         @(posedge clk); #1;
      end
      en2 = 1'b0;
      pulse2 = '0;
      repeat (5) @(posedge clk);
      #1;
      chk("pending_strobes",    64'(q1.size()), 64'd0);
      chk("pending_strobes600", 64'(q2.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
